ysyx_25040111_refill: RTL
=========================

YSYX_25040111_REFILL -- requirements
Module: ysyx_25040111_refill

Interface
REQ-001 The block SHALL use parameter AXI_ID, default 4'h1, as the ARID driven on every burst.
REQ-002 The block SHALL use parameter MAX_LEN, default 8'd7, as the largest accepted req_len (beats minus 1).
REQ-003 clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid / req_ready  in / out  1 each  refill request handshake from the cache.
REQ-006 req_addr  in  32  burst start address, word aligned.
REQ-007 req_len  in  8  beats minus 1.
REQ-008 beat_valid / beat_ready  out / in  1 each  refill data handshake to the cache.
REQ-009 beat_data  out  32  one returned word.
REQ-010 beat_idx  out  8  beat number within the burst, starting at 0.
REQ-011 beat_last  out  1  final beat of the burst.
REQ-012 err  out  1  sticky error flag for the current burst.
REQ-013 io_master_ar{valid,addr,id,len,size,burst}  out  1/32/4/8/3/2  AXI4 read address channel.
REQ-014 io_master_arready  in  1  AXI4 read address channel ready.
REQ-015 io_master_r{valid,data,resp,last,id}  in  1/32/2/1/4  AXI4 read data channel.
REQ-016 io_master_rready  out  1  AXI4 read data channel ready.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ADDR, DATA, DRAIN.
REQ-018 req_ready SHALL equal 1 only in IDLE.
REQ-019 In IDLE, on req_valid&req_ready, the block SHALL latch addr and len = min(req_len, MAX_LEN), clear err, clear the beat counter, and go to ADDR.
REQ-020 In ADDR, arvalid SHALL be 1, with araddr=latched addr, arid=AXI_ID, arlen=latched len, arsize=3'b010, arburst=2'b01 (INCR).
REQ-021 All AR outputs SHALL stay stable until io_master_arready; arvalid SHALL be 0 in every state except ADDR.
REQ-022 On arvalid&arready the FSM SHALL go to DATA.
REQ-023 Output path: beat_data, beat_idx and beat_last SHALL come from a one-entry output register, with beat_valid as its valid bit.
REQ-024 rready SHALL equal (state==DATA) & (~beat_valid | beat_ready).
REQ-025 Each accepted R beat SHALL load the output register the next cycle: beat_idx=counter, beat_last=rlast, beat_data=rdata.
REQ-026 Each accepted R beat SHALL increment the counter by 1, saturating at 8'hFF.
REQ-027 When beat_valid&beat_ready and no new beat is loaded in the same cycle, beat_valid SHALL clear; a simultaneous load and drain SHALL keep beat_valid=1.
REQ-028 An R beat with rresp!=2'b00 SHALL set err.
REQ-029 An R beat with rid!=AXI_ID SHALL set err.
REQ-030 rlast on a beat with counter!=len SHALL set err.
REQ-031 A beat with counter==len and rlast=0 SHALL set err.
REQ-032 Once err is set it SHALL hold until the next request is accepted.
REQ-033 Beats with counter>len SHALL be accepted from AXI but not loaded: beat_valid unchanged, no data forwarded.
REQ-034 The burst SHALL end on the R beat carrying rlast: the FSM goes to DRAIN.
REQ-035 Neither len nor a beat count SHALL end the burst early.
REQ-036 In DRAIN, rready SHALL be 0 and the FSM SHALL go to IDLE when beat_valid==0, or in the cycle beat_valid&beat_ready.
REQ-037 Latency: the first beat_valid SHALL assert exactly 1 cycle after the first rvalid&rready.
REQ-038 With beat_ready held at 1, the block SHALL sustain 1 beat per cycle.
REQ-039 req_valid asserted outside IDLE SHALL be ignored, with no queueing.

Reset
REQ-040 Reset low SHALL immediately, asynchronously, force: state=IDLE, arvalid=0, rready=0, beat_valid=0, beat_last=0, beat_idx=0, beat_data=0, err=0, counter=0, latched addr/len=0.
REQ-041 Reset asserted mid-burst SHALL abandon the burst with no further beats presented; outstanding AXI beats after release are the interconnect's responsibility.
REQ-042 The first request SHALL be accepted no earlier than the first rising edge after reset deasserts.

Verification
REQ-043 Basic burst: req addr=0x3000_0000, len=3; arready after 2 cycles; 4 R beats 0xA0..0xA3, rresp=0, last on 4th -> araddr=0x3000_0000, arlen=3, arsize=2, arburst=1; beats idx 0..3 in order, beat_last only on idx 3, err=0, FSM back in IDLE.
REQ-044 Backpressure: beat_ready held 0 for 5 cycles with beat_valid=1 -> rready=0, beat_data stable; on release, beats continue 1/cycle with no loss or duplication.
REQ-045 Slave error: rresp=2'b10 on beat 1 of len=3 -> err=1 from the next cycle through the end of the burst; all 4 beats still delivered; err cleared at the next req accept.
REQ-046 Early rlast: len=7, rlast on beat 2 -> err=1, beat_last on idx 2, FSM goes DRAIN then IDLE.
REQ-047 Late rlast: len=1, rlast on beat 3 -> err=1, only idx 0 and 1 reach beat output, beats 2 and 3 consumed, FSM goes DRAIN then IDLE.
REQ-048 Reset mid-DATA after 2 beats -> all outputs at reset values in the same cycle; req_ready=1 after release.

Source files
------------

// File: rtl/ysyx_25040111_refill.sv
// Cache refill engine: turns one refill request into a single AXI4 INCR read burst
// and forwards the returned words through a one-entry output register.
module ysyx_25040111_refill #(
    parameter logic [3:0] AXI_ID  = 4'h1,
    parameter logic [7:0] MAX_LEN = 8'd7
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,

    output logic        beat_valid,
    input  logic        beat_ready,
    output logic [31:0] beat_data,
    output logic [7:0]  beat_idx,
    output logic        beat_last,
    output logic        err,

    output logic        io_master_arvalid,
    input  logic        io_master_arready,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,

    input  logic        io_master_rvalid,
    output logic        io_master_rready,
    input  logic [31:0] io_master_rdata,
    input  logic [1:0]  io_master_rresp,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        bvalid_q, bvalid_d;
    logic [31:0] bdata_q, bdata_d;
    logic [7:0]  bidx_q, bidx_d;
    logic        blast_q, blast_d;

    logic r_fire;
    logic beat_fire;
    logic load;
    logic beat_bad;

    assign req_ready         = (state_q == S_IDLE);
    assign io_master_arvalid = (state_q == S_ADDR);
    assign io_master_araddr  = addr_q;
    assign io_master_arid    = AXI_ID;
    assign io_master_arlen   = len_q;
    assign io_master_arsize  = 3'b010;
    assign io_master_arburst = 2'b01;
    assign io_master_rready  = (state_q == S_DATA) & (~bvalid_q | beat_ready);

    assign r_fire    = io_master_rvalid & io_master_rready;
    assign beat_fire = bvalid_q & beat_ready;
    // Beats past the requested length are still drained from AXI but never forwarded.
    assign load      = r_fire & (cnt_q <= len_q);
    assign beat_bad  = (io_master_rresp != 2'b00) | (io_master_rid != AXI_ID)
                     | (io_master_rlast & (cnt_q != len_q))
                     | ((cnt_q == len_q) & ~io_master_rlast);

    assign beat_valid = bvalid_q;
    assign beat_data  = bdata_q;
    assign beat_idx   = bidx_q;
    assign beat_last  = blast_q;
    assign err        = err_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        bvalid_d = bvalid_q;
        bdata_d  = bdata_q;
        bidx_d   = bidx_q;
        blast_d  = blast_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    len_d   = (req_len > MAX_LEN) ? MAX_LEN : req_len;
                    err_d   = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (io_master_arready) state_d = S_DATA;
            end
            S_DATA: begin
                if (r_fire) begin
                    cnt_d = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
                    if (beat_bad)        err_d   = 1'b1;
                    if (io_master_rlast) state_d = S_DRAIN;
                end
            end
            default: begin
                if (!bvalid_q || beat_ready) state_d = S_IDLE;
            end
        endcase

        // A load in the same cycle as a drain keeps the register full.
        if (load) begin
            bvalid_d = 1'b1;
            bdata_d  = io_master_rdata;
            bidx_d   = cnt_q;
            blast_d  = io_master_rlast;
        end else if (beat_fire) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            len_q    <= 8'd0;
            cnt_q    <= 8'd0;
            err_q    <= 1'b0;
            bvalid_q <= 1'b0;
            bdata_q  <= 32'd0;
            bidx_q   <= 8'd0;
            blast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            bvalid_q <= bvalid_d;
            bdata_q  <= bdata_d;
            bidx_q   <= bidx_d;
            blast_q  <= blast_d;
        end
    end

endmodule
